// File: rtl/ui_bus_arbiter_pkg.sv
// Shared encodings for the UI register-port arbiter: device selects, sequencer
// states and requester ids.
package ui_bus_arbiter_pkg;

  localparam logic [1:0] UI_KEY  = 2'd0;
  localparam logic [1:0] UI_SW   = 2'd1;
  localparam logic [1:0] UI_LEDR = 2'd2;
  localparam logic [1:0] UI_HEX  = 2'd3;

  typedef enum logic [1:0] {
    UIARB_IDLE  = 2'd0,
    UIARB_ISSUE = 2'd1,
    UIARB_RESP  = 2'd2
  } uiarb_state_t;

  typedef enum logic {
    UIARB_A = 1'b0,
    UIARB_B = 1'b1
  } uiarb_port_t;

  // KEY and SW are inputs only; only LEDR and HEX accept writes.
  function automatic logic dev_writable(input logic [1:0] dev);
    return (dev == UI_LEDR) || (dev == UI_HEX);
  endfunction

endpackage

// File: rtl/ui_bus_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick. Purely combinational; the caller keeps the
// last-grant history.
module rr_arbiter2
  import ui_bus_arbiter_pkg::*;
(
  input  logic        req_a,
  input  logic        req_b,
  input  uiarb_port_t last_grant,
  output uiarb_port_t grant_id,
  output logic        grant_vld
);

  always_comb begin
    grant_vld = req_a | req_b;
    grant_id  = UIARB_A;
    if (req_a && req_b) begin
      if (last_grant == UIARB_A) grant_id = UIARB_B;
      else                       grant_id = UIARB_A;
    end else if (req_b) begin
      grant_id = UIARB_B;
    end
  end

endmodule

// File: rtl/ui_bus_arbiter.sv
// Shares the single UI controller register port between a CPU requester (A)
// and a debug requester (B), one transaction at a time.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner's command
// ISSUE | command on the UI port; write strobed, read data captured at exit
// RESP  | winner's ack pulse
module ui_bus_arbiter
  import ui_bus_arbiter_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [1:0]       a_dev,
  input  logic [DBITS-1:0] a_wdata,
  output logic             a_ack,
  output logic             a_err,
  output logic [DBITS-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [1:0]       b_dev,
  input  logic [DBITS-1:0] b_wdata,
  output logic             b_ack,
  output logic             b_err,
  output logic [DBITS-1:0] b_rdata,
  output logic             ui_wrtEn,
  output logic [1:0]       ui_dev,
  output logic [DBITS-1:0] ui_in,
  input  logic [DBITS-1:0] ui_out,
  output logic             busy
);

  uiarb_state_t     r_state;
  uiarb_port_t      r_win;
  uiarb_port_t      r_last_grant;
  logic             r_we;
  logic             r_a_ack, r_b_ack, r_a_err, r_b_err;
  logic [DBITS-1:0] r_a_rdata, r_b_rdata;
  logic             r_ui_wrtEn;
  logic [1:0]       r_ui_dev;
  logic [DBITS-1:0] r_ui_in;
  logic             r_busy;

  uiarb_port_t      w_grant_id;
  logic             w_grant_vld;
  logic             w_sel_we;
  logic [1:0]       w_sel_dev;
  logic [DBITS-1:0] w_sel_wdata;
  logic             w_wr_err;

  rr_arbiter2 u_rr (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_grant (r_last_grant),
    .grant_id   (w_grant_id),
    .grant_vld  (w_grant_vld)
  );

  assign w_sel_we    = (w_grant_id == UIARB_B) ? b_we    : a_we;
  assign w_sel_dev   = (w_grant_id == UIARB_B) ? b_dev   : a_dev;
  assign w_sel_wdata = (w_grant_id == UIARB_B) ? b_wdata : a_wdata;

  // ui_dev holds the latched device for the whole transaction.
  assign w_wr_err = r_we && !dev_writable(r_ui_dev);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= UIARB_IDLE;
      r_win        <= UIARB_A;
      r_last_grant <= UIARB_B;
      r_we         <= 1'b0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_a_err      <= 1'b0;
      r_b_err      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_ui_wrtEn   <= 1'b0;
      r_ui_dev     <= 2'd0;
      r_ui_in      <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        UIARB_IDLE: begin
          if (w_grant_vld) begin
            r_win        <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_we         <= w_sel_we;
            r_ui_dev     <= w_sel_dev;
            r_ui_in      <= w_sel_wdata;
            r_ui_wrtEn   <= w_sel_we && dev_writable(w_sel_dev);
            r_busy       <= 1'b1;
            r_state      <= UIARB_ISSUE;
          end
        end
        UIARB_ISSUE: begin
          r_ui_wrtEn <= 1'b0;
          if (r_win == UIARB_A) begin
            if (!r_we) r_a_rdata <= ui_out;
            r_a_err <= w_wr_err;
            r_a_ack <= 1'b1;
          end else begin
            if (!r_we) r_b_rdata <= ui_out;
            r_b_err <= w_wr_err;
            r_b_ack <= 1'b1;
          end
          r_state <= UIARB_RESP;
        end
        UIARB_RESP: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_a_err <= 1'b0;
          r_b_err <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= UIARB_IDLE;
        end
        default: r_state <= UIARB_IDLE;
      endcase
    end
  end

  // A reset arriving during RESP must cancel the ack already on the wire.
  assign a_ack    = r_a_ack & ~reset;
  assign b_ack    = r_b_ack & ~reset;
  assign a_err    = r_a_err;
  assign b_err    = r_b_err;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign ui_wrtEn = r_ui_wrtEn;
  assign ui_dev   = r_ui_dev;
  assign ui_in    = r_ui_in;
  assign busy     = r_busy;

endmodule

// File: doc/ui_bus_arbiter.md
Name: ui_bus_arbiter

Overview:
Two-port arbiter that shares the single UI device register port (wrtEn/in/uiDevice/out of the UI controller) between requester A (CPU load/store path) and requester B (debug/monitor port). Each port issues one read or write transaction per request. Transactions are serialized through a 3-state sequencer with round-robin arbitration. Read-only devices are protected against writes. The block sits between the memory-mapped I/O decoder and the UI controller.

Parameters:
DBITS, 32, data width of request, response and UI port data.

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high
a_req  input  1  port A transaction request; held, with command, until a_ack
a_we  input  1  port A: 1 = write, 0 = read
a_dev  input  2  port A device select (`UI_KEY/`UI_SW/`UI_LEDR/`UI_HEX)
a_wdata  input  DBITS  port A write data
a_ack  output  1  port A one-cycle completion pulse
a_err  output  1  port A error flag, valid with a_ack
a_rdata  output  DBITS  port A read data, valid with a_ack, held until next A ack
b_req, b_we, b_dev, b_wdata  input  1/1/2/DBITS  port B, same as A
b_ack, b_err, b_rdata  output  1/1/DBITS  port B, same as A
ui_wrtEn  output  1  to UI controller write enable
ui_dev  output  2  to UI controller device select
ui_in  output  DBITS  to UI controller write data
ui_out  input  DBITS  from UI controller read data (combinational)
busy  output  1  high in ISSUE and RESP

Behaviour:
- Reset (sync): state=IDLE, last_grant=B (A wins first tie), all acks/errs=0, a_rdata=b_rdata=0, ui_wrtEn=0, ui_dev=0, ui_in=0, busy=0.
- States: IDLE, ISSUE, RESP.
- IDLE, any req: pick winner, latch winner id, we, dev, wdata; go to ISSUE.
  - Only one req: that port wins.
  - Both reqs: the port != last_grant wins; last_grant updates to the winner.
  - No req: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - ui_dev=latched dev; ui_in=latched wdata.
  - ui_wrtEn = latched we AND dev in {`UI_LEDR, `UI_HEX}.
  - The UI controller commits the write on the negedge inside this cycle.
  - At the closing posedge: winner's rdata <= ui_out if read, else unchanged; winner's err <= latched we AND dev in {`UI_KEY, `UI_SW}.
  - Go to RESP.
- RESP (1 cycle): winner's ack=1; go to IDLE. reqs are not sampled in RESP.
- Outside ISSUE: ui_wrtEn=0, ui_dev/ui_in hold their last values.
- Latency: req sampled at edge N, ack high during cycle N+2, next grant sampled at edge N+3. Throughput is 1 transaction per 3 cycles.
- Requester holding req high through ack issues a back-to-back transaction. Under sustained dual requests A and B strictly alternate. Max wait for the loser is one transaction.
- Command inputs are ignored after the IDLE latch; changing them mid-transaction has no effect.
- Loser's ack/err stay 0; its rdata is unchanged.
- Read data width: ui_out passes through unmodified; zero-extension is done in the UI controller.
- Reset mid-ISSUE:
  - the negedge write in that cycle still reaches the device;
  - no ack is produced;
  - state returns to IDLE;
  - a still-pending req is re-arbitrated from IDLE.
- Reset during RESP suppresses that ack.
- Invalid/erroneous write: no device state change; transaction completes normally with err=1.

Decomposition:
- Shared header (UiController.vh): `UI_KEY, `UI_SW, `UI_LEDR, `UI_HEX device encodings, plus new state encodings `UIARB_IDLE/`UIARB_ISSUE/`UIARB_RESP and port ids `UIARB_A/`UIARB_B.
- One sub-module: rr_arbiter2.
  - Inputs: req_a, req_b, last_grant.
  - Outputs: grant id, grant valid.
  - Purely combinational; the top owns last_grant.

Test Plan:
- A write: A writes LEDR with wdata=0x2A5. Required: ui_wrtEn=1 only in the cycle after the req edge; a_ack 2 cycles after req; a_err=0. An A read of LEDR then returns a_rdata=0x000002A5.
- B read of SW: B reads SW with switches debounced to 0x155 -> b_rdata=0x00000155, b_ack single pulse, a_ack stays 0.
- Simultaneous requests: A and B req in the same cycle after reset. A writes HEX=0x1234, B reads HEX. Required: A granted first, B second; b_rdata=0x00001234; acks 3 cycles apart.
- Sustained contention: both reqs held high for 12 cycles -> grants A,B,A,B; exactly 4 acks total, alternating.
- Write to read-only device: A writes KEY with data 0xF. Required: ui_wrtEn stays 0 throughout; a_ack=1 with a_err=1; a subsequent read of KEY is unaffected.
- Reset mid-operation: reset asserted during ISSUE of a B read. Required: no b_ack, busy=0 next cycle, b_rdata=0. With b_req still high after reset deasserts, the read completes with b_ack 2 cycles later.
